// File: rtl/rob_pkg.sv
// Shared types and defaults for the reorder buffer.
// Physical tags are one bit wider than an architectural register index.
package rob_pkg;

    localparam int NUM_REG_DEFAULT   = 32;
    localparam int ROB_DEPTH_DEFAULT = 16;

    function automatic int preg_width(input int num_reg);
        return $clog2(num_reg) + 1;
    endfunction

    localparam int PREG_W = preg_width(NUM_REG_DEFAULT);

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              has_rd;
        logic [PREG_W-1:0] prd_old;
        logic [PREG_W-1:0] prd_new;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates from rename, records out-of-order
// completions, retires one instruction per cycle and frees the superseded tag.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int NUM_REG   = NUM_REG_DEFAULT,
    parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT,
    parameter int REG_SIZE  = $clog2(NUM_REG),
    parameter int IDX_W     = $clog2(ROB_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic              alloc_has_rd,
    input  logic [REG_SIZE:0] alloc_prd_old,
    input  logic [REG_SIZE:0] alloc_prd_new,
    output logic [IDX_W-1:0]  alloc_idx,

    input  logic              complete_valid,
    input  logic [IDX_W-1:0]  complete_idx,

    output logic              commit_free,
    output logic [REG_SIZE:0] prd_free,
    output logic              commit_valid,
    output logic [REG_SIZE:0] commit_prd_new,

    output logic              empty,
    output logic [IDX_W:0]    count
);

    rob_entry_t       rob [ROB_DEPTH];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;

    rob_entry_t       head_entry;
    logic             alloc_fire;
    logic             commit_fire;
    logic             commit_release;

    always_comb begin
        head_entry     = rob[head];
        alloc_ready    = (count != (IDX_W+1)'(ROB_DEPTH));
        alloc_fire     = alloc_valid && alloc_ready;
        // done is only ever seen one edge after it was set, so a completion
        // to the head cannot retire on the same edge.
        commit_fire    = head_entry.valid && head_entry.done;
        // p0 is hardwired and must never re-enter the free pool.
        commit_release = head_entry.has_rd && (head_entry.prd_old != '0);
        alloc_idx      = tail;
        empty          = (count == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
                rob[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (complete_valid && rob[complete_idx].valid) begin
                rob[complete_idx].done <= 1'b1;
            end
            if (commit_fire) begin
                rob[head].valid <= 1'b0;
                rob[head].done  <= 1'b0;
                head            <= head + IDX_W'(1);
            end
            if (alloc_fire) begin
                rob[tail].valid   <= 1'b1;
                rob[tail].done    <= 1'b0;
                rob[tail].has_rd  <= alloc_has_rd;
                rob[tail].prd_old <= alloc_prd_old;
                rob[tail].prd_new <= alloc_prd_new;
                tail              <= tail + IDX_W'(1);
            end
            count <= count + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid   <= 1'b0;
            commit_free    <= 1'b0;
            prd_free       <= '0;
            commit_prd_new <= '0;
        end else if (commit_fire) begin
            commit_valid   <= 1'b1;
            commit_free    <= commit_release;
            prd_free       <= head_entry.has_rd ? head_entry.prd_old : '0;
            commit_prd_new <= head_entry.prd_new;
        end else begin
            commit_valid   <= 1'b0;
            commit_free    <= 1'b0;
            prd_free       <= '0;
            commit_prd_new <= '0;
        end
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order reorder buffer that sits directly downstream of the rename stage. It accepts one renamed instruction per cycle, carrying its old and new physical destination registers. It records out-of-order completion reports and retires at most one instruction per cycle in program order. At retirement it returns the superseded physical register to the rename free pool through `prd_free` / `commit_free`.

## Interface
- `NUM_REG`, 32, architectural register count; `REG_SIZE = $clog2(NUM_REG)`, physical tags are `REG_SIZE+1` bits
- `ROB_DEPTH`, 16, entry count; must be a power of two ≥ 2; `IDX_W = $clog2(ROB_DEPTH)`
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `alloc_valid`  in  1  rename presents an instruction this cycle
- `alloc_ready`  out  1  buffer can accept; equals `count != ROB_DEPTH`
- `alloc_has_rd`  in  1  instruction writes a nonzero architectural rd
- `alloc_prd_old`  in  REG_SIZE+1  previous mapping of rd (from rename `prd_A_old`)
- `alloc_prd_new`  in  REG_SIZE+1  new mapping of rd (from rename `prd_A_new`)
- `alloc_idx`  out  IDX_W  tail index given to the instruction being allocated (combinational, equals tail pointer)
- `complete_valid`  in  1  execution reports an instruction finished
- `complete_idx`  in  IDX_W  ROB index of the finished instruction
- `commit_free`  out  1  registered; pulse: `prd_free` is released this cycle
- `prd_free`  out  REG_SIZE+1  registered; physical register to return to free pool
- `commit_valid`  out  1  registered; pulse: one instruction retired
- `commit_prd_new`  out  REG_SIZE+1  registered; committed mapping (for architectural map / debug)
- `empty`  out  1  `count == 0`
- `count`  out  IDX_W+1  occupied entries

## Operation
- Per-entry state: `valid`, `done`, `has_rd`, `prd_old`, `prd_new`. Head and tail pointers are IDX_W bits and wrap naturally mod ROB_DEPTH.
- Allocate: when `alloc_valid && alloc_ready`, write the tail entry with `valid=1`, `done=0` and the payload, then increment tail.
- Complete: when `complete_valid` and `entry[complete_idx].valid`, set `done=1`. A completion to an invalid entry is ignored. A duplicate completion is harmless.
- Commit: when `entry[head].valid && entry[head].done`, clear `valid` and increment head. The same edge registers `commit_valid=1`, `commit_prd_new=prd_new`, `commit_free=has_rd`, `prd_free = has_rd ? prd_old : 0`. Otherwise all four register to 0.
- Never free p0. If `has_rd` is set but `prd_old == 0`, suppress `commit_free`.
- `count` next-state is `count + alloc_fire - commit_fire`. Simultaneous alloc and commit leaves count unchanged.
- `alloc_ready` uses the current count only. A commit in the same cycle does not allow allocation while full (no bypass).

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - head=tail=0, count=0
  - all `valid`/`done` = 0
  - `commit_valid=commit_free=0`, `prd_free=commit_prd_new=0`
  - `empty=1`, `alloc_ready=1`
- Reset mid-operation discards all entries. No commit pulse is produced for them.
- Minimum latency:
  - alloc accepted at edge N
  - completion accepted at edge N+1 at the earliest
  - commit outputs valid in cycle after edge N+2
- A completion to the head index takes effect at edge E. The head commits at edge E+1; there is no same-edge complete-and-commit.
- At most one commit per cycle. Back-to-back done entries retire on consecutive cycles.
- Wrap-around: tail/head rolling from ROB_DEPTH-1 to 0 is transparent. A full buffer has head==tail with count==ROB_DEPTH.

## Structure
- Shared package `rob_pkg`:
  - `rob_entry_t` struct (`valid`, `done`, `has_rd`, `prd_old`, `prd_new`)
  - `ROB_DEPTH` default
  - physical-tag width derivation from `NUM_REG`
- Single module. Commit-output registers are kept in the same file. No sub-module is needed.

## Test plan
- Reset then idle: `empty=1`, `count=0`, `alloc_ready=1`, no commit pulses for 10 cycles.
- In-order sequence:
  - Stimulus: allocate 3 entries (old/new = 5/33, 6/34, 7/35), complete idx 0, 1, 2 on consecutive cycles.
  - Required: `prd_free` = 5, 6, 7 with `commit_free` on consecutive cycles; `count` returns to 0.
- Out-of-order completion:
  - Stimulus: allocate 3, complete idx 2, then idx 1.
  - Required: no commit. After completing idx 0, three consecutive commits in order 0, 1, 2.
- Full/wrap:
  - Allocate 16 entries; `alloc_ready=0`.
  - Complete head; alloc held during the commit cycle is refused.
  - Then one alloc succeeds at idx 0 after wrap; `count=16`.
- rd=x0 entry: `alloc_has_rd=0` → `commit_valid=1` with `commit_free=0`, `prd_free=0`.
- Async reset asserted with 5 entries, 2 done: outputs clear immediately, and no commit pulse follows deassertion.
